round_key_sequencer: RTL and testbench

- Parametrised successor to the single-mode round-key selector.
- Streams 128-bit round keys out of the full expanded-key vector to the round datapath, one key per request.
- Supports AES-128/192/256 round counts and both encrypt (forward) and decrypt (reverse) key order.
- Uses a valid/next handshake with start, abort, done and error signalling. Sits between key expansion and the round engine.

---
 rtl/round_key_sequencer.sv | 121 ++++++++++++
 tb/tb_round_key_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: streams 128-bit round keys from the expanded-key vector
// in forward or reverse order for AES-128/192/256, one key per next request.
module round_key_sequencer #(
  parameter int KEY_W      = 128,
  parameter int MAX_ROUNDS = 14,
  parameter int EXP_W      = KEY_W * (MAX_ROUNDS + 1),
  parameter int IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic [1:0]         key_len,
  input  logic [EXP_W-1:0]   key_exp,
  input  logic               next,
  input  logic               abort,
  output logic [KEY_W-1:0]   round_key,
  output logic [IDX_W-1:0]   round_idx,
  output logic               key_valid,
  output logic               last_key,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] nr_q, nr_d;
  logic             dec_q, dec_d;
  logic [IDX_W-1:0] idx_d;
  logic             load_key;
  logic             done_d, err_d;
  logic [IDX_W-1:0] nr_sel;

  // Block 0 sits in the most-significant KEY_W bits of key_exp.
  function automatic logic [KEY_W-1:0] blk_sel(input logic [IDX_W-1:0] idx,
                                               input logic [EXP_W-1:0] vec);
    blk_sel = '0;
    for (int i = 0; i <= MAX_ROUNDS; i++) begin
      if (idx == i[IDX_W-1:0]) blk_sel = vec[EXP_W-1-i*KEY_W -: KEY_W];
    end
  endfunction

  always_comb begin
    case (key_len)
      2'd1:    nr_sel = IDX_W'(12);
      2'd2:    nr_sel = IDX_W'(14);
      default: nr_sel = IDX_W'(10);
    endcase
  end

  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign last_key  = key_valid & (dec_q ? (round_idx == '0) : (round_idx == nr_q));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    state_d  = state;
    nr_d     = nr_q;
    dec_d    = dec_q;
    idx_d    = round_idx;
    load_key = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (key_len == 2'd3) begin
            err_d = 1'b1;
          end else begin
            nr_d     = nr_sel;
            dec_d    = decrypt;
            idx_d    = decrypt ? nr_sel : '0;
            load_key = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        // abort wins over a simultaneous next; start is ignored here.
        if (abort) begin
          state_d = IDLE;
        end else if (next) begin
          if (last_key) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d    = dec_q ? round_idx - IDX_W'(1) : round_idx + IDX_W'(1);
            load_key = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      nr_q      <= IDX_W'(10);
      dec_q     <= 1'b0;
      round_idx <= '0;
      round_key <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      nr_q      <= nr_d;
      dec_q     <= dec_d;
      round_idx <= idx_d;
      done      <= done_d;
      err       <= err_d;
      if (load_key) round_key <= blk_sel(idx_d, key_exp);
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench for round_key_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a key-list model.
module tb_round_key_sequencer;

  localparam int KEY_W = 128;
  localparam int NBLK  = 15;
  localparam int EXP_W = KEY_W * NBLK;

  logic             clk = 1'b0;
  logic             rst, start, decrypt, next, abort;
  logic [1:0]       key_len;
  logic [EXP_W-1:0] key_exp;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       round_idx;
  logic             key_valid, last_key, busy, done, err;

  round_key_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_len(key_len),
    .key_exp(key_exp), .next(next), .abort(abort), .round_key(round_key),
    .round_idx(round_idx), .key_valid(key_valid), .last_key(last_key),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, done_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: at start the whole index list of the sequence is written out,
  // and the model just walks a position pointer through that list.
  logic [KEY_W-1:0] blkm [NBLK];
  int               m_seq [NBLK];
  int               m_nr = 10, m_pos = 0;
  bit               m_active = 0, m_done = 0, m_err = 0;
  logic [3:0]       m_idx = '0;
  logic [KEY_W-1:0] m_key = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_pos = 0; m_idx = '0; m_key = '0;
    end else begin
      m_done = 0; m_err = 0;
      if (!m_active) begin
        if (start) begin
          if (key_len == 2'd3) m_err = 1;
          else begin
            m_nr = 10 + 2 * int'(key_len);
            for (int k = 0; k <= m_nr; k++) m_seq[k] = decrypt ? m_nr - k : k;
            m_pos = 0; m_active = 1;
            m_idx = 4'(m_seq[0]); m_key = blkm[m_seq[0]];
          end
        end
      end else if (abort) begin
        m_active = 0;
      end else if (next) begin
        if (m_pos == m_nr) begin
          m_active = 0; m_done = 1;
        end else begin
          m_pos++;
          m_idx = 4'(m_seq[m_pos]); m_key = blkm[m_seq[m_pos]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("round_key", round_key, m_key);
      check("round_idx", 128'(round_idx), 128'(m_idx));
      check("key_valid", 128'(key_valid), 128'(m_active));
      check("busy", 128'(busy), 128'(m_active));
      check("last_key", 128'(last_key), 128'(m_active && m_pos == m_nr));
      check("done", 128'(done), 128'(m_done));
      check("err", 128'(err), 128'(m_err));
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_fill(input bit pattern);
    logic [EXP_W-1:0] kx;
    kx = '0;
    for (int i = 0; i < NBLK; i++) begin
      blkm[i] = pattern ? {16{8'(i)}} : {$urandom, $urandom, $urandom, $urandom};
      kx = {kx[EXP_W-KEY_W-1:0], blkm[i]};
    end
    key_exp = kx;
  endtask

  task automatic start_seq(input logic [1:0] kl, input logic dec);
    start = 1'b1; key_len = kl; decrypt = dec;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idx(input int target);
    for (int c = 0; c < 40 && int'(round_idx) != target; c++) tick();
    check("reach_idx", 128'(round_idx), 128'(target));
  endtask

  task automatic finish_seq();
    for (int c = 0; c < 100 && key_valid; c++) tick();
    check("seq_end", 128'(key_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nk, d0;
    logic [3:0] last_idx;
    rst = 1'b0; start = 1'b0; decrypt = 1'b0; next = 1'b0; abort = 1'b0; key_len = 2'd0;
    set_fill(1);
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_key", round_key, 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b1;
    tick();

    // AES-128 forward, next held high.
    next = 1'b1; nk = 0;
    start_seq(2'd0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      check("fwd_idx", 128'(round_idx), 128'(k));
      check("fwd_key", round_key, {16{8'(k)}});
      check("fwd_last", 128'(last_key), 128'(k == 10));
      if (key_valid) nk++;
      tick();
    end
    check("fwd_count", 128'(nk), 128'(11));
    check("fwd_done", 128'(done), 128'(1));
    check("fwd_valid_off", 128'(key_valid), 128'(0));
    tick();
    check("fwd_done_pulse", 128'(done), 128'(0));

    // AES-256 reverse.
    nk = 0;
    start_seq(2'd2, 1'b1);
    for (int k = 14; k >= 0; k--) begin
      check("rev_idx", 128'(round_idx), 128'(k));
      check("rev_key", round_key, {16{8'(k)}});
      check("rev_last", 128'(last_key), 128'(k == 0));
      if (key_valid) nk++;
      tick();
    end
    check("rev_count", 128'(nk), 128'(15));
    check("rev_done", 128'(done), 128'(1));
    tick();

    // AES-192 forward with next toggling.
    next = 1'b0; nk = 0; last_idx = '0;
    start_seq(2'd1, 1'b0);
    d0 = done_cnt;
    for (int c = 0; c < 100 && key_valid; c++) begin
      next = (c % 2 == 0);
      if (next) begin nk++; last_idx = round_idx; end
      tick();
    end
    next = 1'b0;
    check("tog_count", 128'(nk), 128'(13));
    check("tog_final_idx", 128'(last_idx), 128'(12));
    tick();
    check("tog_done_once", 128'(done_cnt - d0), 128'(1));

    // Illegal key length.
    start_seq(2'd3, 1'b0);
    check("err_pulse", 128'(err), 128'(1));
    check("err_busy", 128'(busy), 128'(0));
    check("err_valid", 128'(key_valid), 128'(0));
    check("err_no_done", 128'(done), 128'(0));
    tick();
    check("err_clear", 128'(err), 128'(0));

    // Abort together with next at idx 4.
    next = 1'b1;
    start_seq(2'd0, 1'b0);
    run_to_idx(4);
    abort = 1'b1;
    tick();
    abort = 1'b0; next = 1'b0;
    check("abort_valid", 128'(key_valid), 128'(0));
    check("abort_idx", 128'(round_idx), 128'(4));
    check("abort_no_done", 128'(done), 128'(0));
    tick();
    check("abort_no_done2", 128'(done), 128'(0));
    next = 1'b1;
    start_seq(2'd0, 1'b0);
    check("restart_idx", 128'(round_idx), 128'(0));
    check("restart_valid", 128'(key_valid), 128'(1));
    finish_seq();
    tick();

    // Reset mid-sequence at idx 6.
    start_seq(2'd0, 1'b0);
    run_to_idx(6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_key", round_key, 128'(0));
    check("mrst_idx", 128'(round_idx), 128'(0));
    check("mrst_valid", 128'(key_valid), 128'(0));
    check("mrst_done", 128'(done), 128'(0));

    // start during RUN is ignored.
    start_seq(2'd0, 1'b0);
    run_to_idx(3);
    start = 1'b1; key_len = 2'd2; decrypt = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt; last_idx = '0;
    for (int c = 0; c < 100 && key_valid; c++) begin
      last_idx = round_idx;
      tick();
    end
    check("ign_final_idx", 128'(last_idx), 128'(10));
    tick();
    check("ign_done_once", 128'(done_cnt - d0), 128'(1));

    // Randomized traffic, fresh random key fill per chunk.
    for (int ch = 0; ch < 4; ch++) begin
      rst = 1'b0; start = 1'b0; next = 1'b0; abort = 1'b0;
      tick();
      rst = 1'b1;
      set_fill(0);
      for (int c = 0; c < 800; c++) begin
        start   = ($urandom_range(0, 7) == 0);
        key_len = 2'($urandom_range(0, 3));
        decrypt = 1'($urandom_range(0, 1));
        next    = ($urandom_range(0, 2) != 0);
        abort   = ($urandom_range(0, 39) == 0);
        rst     = ($urandom_range(0, 299) != 0);
        tick();
      end
    end
    rst = 1'b1; start = 1'b0; next = 1'b0; abort = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
